// File: rtl/stumps_bist_engine.sv
// STUMPS logic-BIST controller: a PRPG feeds the scan chains through a phase
// shifter, and a MISR compacts the chain tails over NUM_ROUNDS shift/capture rounds.
module stumps_bist_engine #(
    parameter int NUM_CHAINS = 4,
    parameter int SHIFT_CNT  = 24,
    parameter int NUM_ROUNDS = 100,
    parameter int PRPG_SIZE  = 16,
    parameter int MISR_SIZE  = 16
) (
    input  logic                  clk,
    input  logic                  masterRstN,
    input  logic                  start,
    input  logic                  abort,
    input  logic [PRPG_SIZE-1:0]  prpgPoly,
    input  logic [PRPG_SIZE-1:0]  prpgSeed,
    input  logic [MISR_SIZE-1:0]  misrPoly,
    input  logic [MISR_SIZE-1:0]  misrSeed,
    input  logic [MISR_SIZE-1:0]  goldenSig,
    output logic [NUM_CHAINS-1:0] scanIn,
    input  logic [NUM_CHAINS-1:0] scanOut,
    output logic                  NbarT,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [MISR_SIZE-1:0]  signature,
    output logic [2:0]            fsm_state
);

    // start and abort are single-cycle level requests sampled on the rising edge;
    // start counts only in IDLE/DONE, abort only while busy, and abort wins over start.

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        SHIFT   = 3'd2,
        CAPTURE = 3'd3,
        UNLOAD  = 3'd4,
        COMPARE = 3'd5,
        DONE    = 3'd6
    } state_t;

    localparam int SW = $clog2(SHIFT_CNT + 1);
    localparam int RW = $clog2(NUM_ROUNDS + 1);
    localparam logic [SW-1:0] SHIFT_LAST = SW'(SHIFT_CNT - 1);
    localparam logic [RW-1:0] ROUND_LAST = RW'(NUM_ROUNDS - 1);

    state_t               state;
    logic [PRPG_SIZE-1:0] prpg;
    logic [MISR_SIZE-1:0] misr;
    logic [PRPG_SIZE-1:0] prpg_poly_q;
    logic [MISR_SIZE-1:0] misr_poly_q;
    logic [MISR_SIZE-1:0] golden_q;
    logic [SW-1:0]        shift_cnt;
    logic [RW-1:0]        round_cnt;
    logic [PRPG_SIZE-1:0] prpg_next;
    logic [MISR_SIZE-1:0] misr_next;

    assign prpg_next = {prpg[PRPG_SIZE-2:0], ^(prpg & prpg_poly_q)};
    assign misr_next = {misr[MISR_SIZE-2:0], ^(misr & misr_poly_q)} ^ MISR_SIZE'(scanOut);

    // Phase shifter spreads the chains evenly along the PRPG.
    for (genvar k = 0; k < NUM_CHAINS; k++) begin : g_phase
        localparam int TAP = (k * PRPG_SIZE) / NUM_CHAINS;
        assign scanIn[k] = prpg[TAP];
    end

    assign signature = misr;
    assign fsm_state = state;

    always_ff @(posedge clk or negedge masterRstN) begin
        if (!masterRstN) begin
            state       <= IDLE;
            prpg        <= '0;
            misr        <= '0;
            prpg_poly_q <= '0;
            misr_poly_q <= '0;
            golden_q    <= '0;
            shift_cnt   <= '0;
            round_cnt   <= '0;
            NbarT       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
        end else if (abort && busy) begin
            state <= IDLE;
            NbarT <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= INIT;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        pass  <= 1'b0;
                    end
                end
                INIT: begin
                    // An all-zero seed would lock the PRPG up, so it becomes 1.
                    prpg        <= (prpgSeed == '0) ? PRPG_SIZE'(1) : prpgSeed;
                    misr        <= misrSeed;
                    prpg_poly_q <= prpgPoly;
                    misr_poly_q <= misrPoly;
                    golden_q    <= goldenSig;
                    shift_cnt   <= '0;
                    round_cnt   <= '0;
                    NbarT       <= 1'b1;
                    state       <= SHIFT;
                end
                SHIFT: begin
                    prpg <= prpg_next;
                    misr <= misr_next;
                    if (shift_cnt == SHIFT_LAST) begin
                        shift_cnt <= '0;
                        NbarT     <= 1'b0;
                        state     <= CAPTURE;
                    end else begin
                        shift_cnt <= shift_cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    round_cnt <= round_cnt + 1'b1;
                    NbarT     <= 1'b1;
                    state     <= (round_cnt == ROUND_LAST) ? UNLOAD : SHIFT;
                end
                UNLOAD: begin
                    prpg <= prpg_next;
                    misr <= misr_next;
                    if (shift_cnt == SHIFT_LAST) begin
                        shift_cnt <= '0;
                        NbarT     <= 1'b0;
                        state     <= COMPARE;
                    end else begin
                        shift_cnt <= shift_cnt + 1'b1;
                    end
                end
                COMPARE: begin
                    pass  <= (misr == golden_q);
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                    NbarT <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/stumps_bist_engine.md
STUMPS_BIST_ENGINE -- requirements
Module: stumps_bist_engine

Interface
REQ-001 Parameter NUM_CHAINS, default 4: number of scan channels, 1..MISR_SIZE.
REQ-002 Parameter SHIFT_CNT, default 24: shift cycles per round, >=1.
REQ-003 Parameter NUM_ROUNDS, default 100: capture rounds per session, >=1.
REQ-004 Parameter PRPG_SIZE, default 16: PRPG length, >=NUM_CHAINS.
REQ-005 Parameter MISR_SIZE, default 16: MISR length.
REQ-006 clk  in  1  sole clock, all state on rising edge.
REQ-007 masterRstN  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  one-cycle request to begin a session.
REQ-009 abort  in  1  synchronous session cancel.
REQ-010 prpgPoly, prpgSeed  in  PRPG_SIZE each  PRPG feedback taps and seed.
REQ-011 misrPoly, misrSeed, goldenSig  in  MISR_SIZE each  MISR taps, seed, expected signature.
REQ-012 scanIn  out  NUM_CHAINS  serial data to chain heads.
REQ-013 scanOut  in  NUM_CHAINS  serial data from chain tails.
REQ-014 NbarT  out  1  1 = test/shift mode, 0 = normal/capture.
REQ-015 busy, done, pass  out  1 each  session active, session complete, signature match.
REQ-016 signature  out  MISR_SIZE  current MISR contents.

Function
REQ-017 FSM states: IDLE, INIT, SHIFT, CAPTURE, UNLOAD, COMPARE, DONE.
REQ-018 IDLE or DONE with start=1 -> INIT; done, pass cleared on that edge.
REQ-019 INIT (1 cycle): load prpgSeed into PRPG (all-zero seed replaced by 1), misrSeed into MISR, clear counters; -> SHIFT.
REQ-020 SHIFT (SHIFT_CNT cycles): NbarT=1, PRPG and MISR step every cycle; on last cycle -> CAPTURE.
REQ-021 CAPTURE (1 cycle): NbarT=0, PRPG and MISR hold, round counter increments; -> SHIFT if rounds < NUM_ROUNDS, else -> UNLOAD.
REQ-022 UNLOAD (SHIFT_CNT cycles): NbarT=1, PRPG and MISR step; -> COMPARE.
REQ-023 COMPARE (1 cycle): pass <= (MISR == goldenSig); -> DONE.
REQ-024 DONE: done=1, pass and signature held until next start or reset.
REQ-025 PRPG step: next = {prpg[PRPG_SIZE-2:0], ^(prpg & prpgPoly)}.
REQ-026 MISR step: next = {misr[MISR_SIZE-2:0], ^(misr & misrPoly)} XOR zero-extended scanOut.
REQ-027 Phase shifter: scanIn[k] = prpg[(k*PRPG_SIZE)/NUM_CHAINS], combinational from PRPG register.
REQ-028 Configuration inputs sampled only in INIT; changes in other states have no effect.
REQ-029 busy=1 in INIT through COMPARE, 0 in IDLE and DONE.
REQ-030 Latency: done rises T = NUM_ROUNDS*(SHIFT_CNT+1)+SHIFT_CNT+2 clock edges after the edge sampling start.
REQ-031 start while busy is ignored.
REQ-032 abort=1 while busy -> IDLE next edge, done=0, pass=0; abort has priority over start; abort in IDLE/DONE ignored.
REQ-033 Counters sized by $clog2 of their limits; no wrap before terminal count.

Reset
REQ-034 masterRstN=0 forces, asynchronously: state IDLE, PRPG=0, MISR=0, counters=0, NbarT=0, busy=0, done=0, pass=0.
REQ-035 Reset mid-session discards the session; after release engine waits in IDLE for start.

Verification
REQ-036 NUM_CHAINS=2, SHIFT_CNT=3, NUM_ROUNDS=2, start pulse -> busy next edge, done exactly 13 edges after start; NbarT pattern 1,1,1,0,1,1,1,0,1,1,1 over SHIFT/CAPTURE/UNLOAD.
REQ-037 Default params, scanOut tied 0, goldenSig from reference model -> pass=1, done at edge 2526; same run with one scanOut bit flipped once -> pass=0.
REQ-038 prpgSeed=0, prpgPoly=16'h002D -> PRPG starts at 1, scanIn never stuck at 0 across session.
REQ-039 abort at cycle 5 of session -> IDLE next edge, done=0; subsequent start runs full T cycles with identical signature to an unaborted run.
REQ-040 masterRstN low mid-SHIFT -> all outputs 0 immediately without clock edge; start while busy -> no restart, done timing unchanged.
